// File: rtl/horner_poly_eval.sv
// Iterative Horner polynomial evaluator: one shared multiply-add per clock.
// Define SATURATE_EN to clamp the product and sum on overflow instead of wrapping.
module horner_poly_eval #(
  parameter int WIDTHIN  = 16,
  parameter int FRACIN   = 14,
  parameter int WIDTHOUT = 32,
  parameter int FRACOUT  = 25,
  parameter int DEGREE   = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [WIDTHIN-1:0]           i_x,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [WIDTHOUT-1:0]          o_y,
  output logic                         o_ovf,
  input  logic                         coef_we,
  input  logic [$clog2(DEGREE+1)-1:0]  coef_addr,
  input  logic [WIDTHOUT-1:0]          coef_wdata
);

  localparam int AW = $clog2(DEGREE+1);
  localparam int PW = WIDTHOUT + WIDTHIN;

  localparam logic [WIDTHOUT-1:0] MAX_V =
    {1'b0, {(WIDTHOUT-1){1'b1}}};
  localparam logic [WIDTHOUT-1:0] MIN_V =
    {1'b1, {(WIDTHOUT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [WIDTHOUT-1:0]        coef_q [DEGREE+1];
  logic [WIDTHOUT-1:0]        coef_d [DEGREE+1];
  logic signed [WIDTHOUT-1:0] acc_q, acc_d;
  logic signed [WIDTHIN-1:0]  x_q, x_d;
  logic [AW-1:0]              cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic [WIDTHOUT-1:0]        y_q, y_d;
  logic                       o_ovf_q, o_ovf_d;
  logic                       valid_q, valid_d;

  logic                       accept;
  logic                       we_ok;
  logic [WIDTHOUT-1:0]        top_coef;
  logic [WIDTHOUT-1:0]        cur_coef;
  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       prod_sh;
  logic                       prod_ovf;
  logic [WIDTHOUT-1:0]        prod_t;
  logic [WIDTHOUT:0]          sum;
  logic                       sum_ovf;
  logic [WIDTHOUT-1:0]        sum_t;
  logic                       step_ovf;

  assign o_ready = (state_q == IDLE) ||
                   (state_q == DONE && i_ready);
  assign accept  = i_valid && o_ready;
  assign we_ok   = coef_we && (state_q == IDLE) &&
                   (int'(coef_addr) <= DEGREE);

  // A coefficient write in the accept cycle must be visible to the load
  assign top_coef = (we_ok && int'(coef_addr) == DEGREE) ?
                    coef_wdata : coef_q[DEGREE];
  assign cur_coef = coef_q[cnt_q];

  always_comb begin
    prod     = acc_q * x_q;
    prod_sh  = prod >>> FRACIN;
    prod_ovf = prod_sh[PW-1:WIDTHOUT-1] !=
               {(WIDTHIN+1){prod_sh[WIDTHOUT-1]}};
`ifdef SATURATE_EN
    if (prod_ovf)
      prod_t = prod_sh[PW-1] ? MIN_V : MAX_V;
    else
      prod_t = prod_sh[WIDTHOUT-1:0];
`else
    prod_t = prod_sh[WIDTHOUT-1:0];
`endif
    sum     = {prod_t[WIDTHOUT-1], prod_t} +
              {cur_coef[WIDTHOUT-1], cur_coef};
    sum_ovf = sum[WIDTHOUT] ^ sum[WIDTHOUT-1];
`ifdef SATURATE_EN
    if (sum_ovf)
      sum_t = sum[WIDTHOUT] ? MIN_V : MAX_V;
    else
      sum_t = sum[WIDTHOUT-1:0];
`else
    sum_t = sum[WIDTHOUT-1:0];
`endif
    step_ovf = prod_ovf | sum_ovf;
  end

  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    y_d     = y_q;
    o_ovf_d = o_ovf_q;
    valid_d = valid_q;

    if (we_ok)
      coef_d[coef_addr] = coef_wdata;

    unique case (state_q)
      IDLE: ;
      CALC: begin
        acc_d = sum_t;
        ovf_d = ovf_q | step_ovf;
        if (cnt_q == '0) begin
          state_d = DONE;
          valid_d = 1'b1;
          y_d     = sum_t;
          o_ovf_d = ovf_q | step_ovf;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      x_d     = i_x;
      acc_d   = top_coef;
      cnt_d   = AW'(DEGREE - 1);
      ovf_d   = 1'b0;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      coef_q  <= '{default: '0};
      acc_q   <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      y_q     <= '0;
      o_ovf_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      y_q     <= y_d;
      o_ovf_q <= o_ovf_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_y     = y_q;
  assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_horner_poly_eval.sv
// Directed bench for horner_poly_eval (default parameters).
// Expected values are hand-computed; overflow case uses a small wrap model.
module tb_horner_poly_eval;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_x;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_y;
  logic        o_ovf;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [31:0] coef_wdata;

  int checks = 0;
  int failures = 0;
  int lat;

  horner_poly_eval dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_x       (i_x),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_y       (o_y),
    .o_ovf     (o_ovf),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic start(input logic [15:0] x);
    i_valid = 1'b1;
    i_x     = x;
    tick();
    i_valid = 1'b0;
    lat     = 1;
  endtask

  // waits for o_valid; lat counts edges since the accept edge
  task automatic wait_done(input string tag);
    while (!o_valid && lat < 40) begin
      tick();
      if (!o_valid) lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd5);
  endtask

  task automatic run(input string tag, input logic [15:0] x,
                     input logic [31:0] y, input logic ov);
    start(x);
    wait_done(tag);
    chk({tag, "_y"}, 64'(o_y), 64'(y));
    chk({tag, "_ovf"}, 64'(o_ovf), 64'(ov));
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, "_idle"}, 64'(o_valid), 64'd0);
  endtask

  function automatic logic [31:0] wrap_model(input logic [31:0] c,
                                             input logic [15:0] x);
    longint acc, p;
    acc = longint'($signed(c));
    for (int k = 0; k < 5; k++) begin
      p   = (acc * longint'($signed(x))) >>> 14;
      acc = longint'($signed(p[31:0])) + longint'($signed(c));
      acc = longint'($signed(acc[31:0]));
    end
    return acc[31:0];
  endfunction

  logic [31:0] ybp;
  logic [31:0] ovf_exp;

  initial begin
    reset      = 1'b0;
    i_valid    = 1'b0;
    i_x        = '0;
    i_ready    = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    tick();
    tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ovf",   64'(o_ovf),   64'd0);
    chk("rst_y",     64'(o_y),     64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    reset = 1'b1;
    tick();

    wr(3'd0, 32'h0200_0000);
    wr(3'd1, 32'h0200_0000);
    wr(3'd2, 32'h0100_0000);
    wr(3'd3, 32'h0055_5555);
    wr(3'd4, 32'h0015_5555);
    wr(3'd5, 32'h0004_4444);

    run("x_one",  16'h4000, 32'h056E_EEEE, 1'b0);
    run("x_zero", 16'h0000, 32'h0200_0000, 1'b0);
    run("x_neg1", 16'hC000, 32'h00BB_BBBC, 1'b0);

    // backpressure, then transfer + accept on the same edge
    start(16'h4000);
    wait_done("bp");
    ybp = o_y;
    chk("bp_y", 64'(ybp), 64'h056E_EEEE);
    i_valid = 1'b1;
    i_x     = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_y",     64'(o_y),     64'h056E_EEEE);
      chk("bp_hold_v",     64'(o_valid), 64'd1);
      chk("bp_hold_ready", 64'(o_ready), 64'd0);
    end
    i_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 64'(o_ready), 64'd1);
    tick();
    i_ready = 1'b0;
    i_valid = 1'b0;
    lat = 1;
    chk("bp_v_after", 64'(o_valid), 64'd0);
    wait_done("bp2");
    chk("bp2_y", 64'(o_y), 64'h0200_0000);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    // write during CALC must be dropped
    start(16'h4000);
    coef_we    = 1'b1;
    coef_addr  = 3'd0;
    coef_wdata = 32'h0;
    tick();
    coef_we = 1'b0;
    lat++;
    wait_done("wcalc");
    chk("wcalc_y", 64'(o_y), 64'h056E_EEEE);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    wr(3'd0, 32'h0);
    run("widle", 16'h4000, 32'h036E_EEEE, 1'b0);
    wr(3'd7, 32'h1234_5678);
    run("waddr7", 16'h4000, 32'h036E_EEEE, 1'b0);

    // saturating / wrapping overflow
    for (int k = 0; k < 6; k++) wr(3'(k), 32'h7FFF_FFFF);
`ifdef SATURATE_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = wrap_model(32'h7FFF_FFFF, 16'h7FFF);
`endif
    run("ovf", 16'h7FFF, ovf_exp, 1'b1);
    run("ovf_clr", 16'h0000, 32'h7FFF_FFFF, 1'b0);

    // reset mid-CALC
    start(16'h4000);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mrst_valid", 64'(o_valid), 64'd0);
    chk("mrst_ready", 64'(o_ready), 64'd1);
    tick();
    chk("mrst_still", 64'(o_valid), 64'd0);
    run("mrst_zero", 16'h4000, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
